alu_shift_seq: RTL
==================

ALU_SHIFT_SEQ -- requirements
Module: alu_shift_seq

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width; SHALL be a power of two, at least 4.
REQ-002 Parameter: AMT_W, default 5, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 Port: clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: clear_n  in  1  reset, synchronous and active-low.
REQ-005 Port: start  in  1  request; accepted only when ready=1.
REQ-006 Port: mode  in  3  operation select: 000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR; 101-111 pass-through.
REQ-007 Port: data_in  in  WIDTH  operand; sampled on the accept edge.
REQ-008 Port: amount  in  AMT_W  shift/rotate count 0..WIDTH-1; sampled on the accept edge.
REQ-009 Port: ready  out  1  high in IDLE and DONE.
REQ-010 Port: busy  out  1  high in RUN.
REQ-011 Port: done  out  1  high for exactly one cycle, in DONE.
REQ-012 Port: result  out  WIDTH  registered result; held until the next completion.
REQ-013 Port: zero  out  1  registered; high when result is all zeros.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, RUN and DONE.
REQ-015 The accept edge is the rising edge with start=1 and ready=1; on it the block SHALL capture data_in, amount and mode into a work register, clear the stage counter and enter RUN.
REQ-016 In RUN, stage k (0..AMT_W-1) SHALL apply a shift or rotate of 2^k positions in the captured mode when amount[k]=1, and pass through otherwise; one stage per edge.
REQ-017 On the edge executing stage AMT_W-1, the block SHALL write the work value to result, update zero and enter DONE; done SHALL go high AMT_W edges after the accept edge.
REQ-018 SHL and SHR SHALL fill with zeros, SHRA SHALL fill with work[WIDTH-1] of the current stage input, and ROL/ROR SHALL wrap bits modulo WIDTH.
REQ-019 Pass-through modes and amount=0 SHALL give result=data_in with the same latency as REQ-017, unless REQ-030 applies.
REQ-020 DONE SHALL last exactly one cycle; the next state SHALL be RUN if start=1, else IDLE.
REQ-021 A start accepted in DONE (back-to-back) SHALL capture new operands on that edge, and result SHALL hold the previous value until the new completion.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the work register, counter, mode or outputs.
REQ-023 Changes on data_in, amount or mode after the accept edge SHALL NOT affect the result in progress.
REQ-024 ready, busy and done SHALL be mutually consistent: ready=!busy, and done implies ready.

Reset
REQ-025 clear_n=0 at a rising edge SHALL force state IDLE and stage counter 0.
REQ-026 The same edge SHALL also force ready=1, busy=0, done=0, result=0 and zero=1.
REQ-027 Reset SHALL take priority over start.
REQ-028 Reset mid-RUN SHALL abandon the operation, with no done pulse and result=0.
REQ-029 After reset is released, the first edge with start=1 SHALL be accepted.

Configuration
REQ-030 Macro ALU_SHIFT_ZERO_BYPASS_EN: when defined, an accept with amount=0 or a pass-through mode SHALL write result=data_in and enter DONE on the accept edge (done one edge later, RUN skipped); when undefined, all requests SHALL take the REQ-017 latency.

Verification (WIDTH=32)
REQ-031 ROL data_in=0x00000003, amount=31 -> result=0x80000001 and done exactly 5 edges after accept; ROR amount=1 -> 0x80000001.
REQ-032 SHRA 0x80000000, amount=4 -> 0xF8000000; SHR -> 0x08000000; SHL 0x00000003, amount=31 -> 0x80000000; SHL 0x1, amount=31 then SHL result by 1 -> 0x00000000, zero=1.
REQ-033 Sweep ROL/ROR of 0x00000003 over amounts 0..31 -> each matches the reference model; back-to-back start held high gives one done every 6 cycles.
REQ-034 Pulse start during RUN with different operands -> ignored; the original result is delivered unchanged.
REQ-035 clear_n=0 two edges after accept -> no done, result=0, zero=1, ready=1; the next start is accepted normally.
REQ-036 amount=0, mode=111 -> result=data_in; done after 1 edge with ALU_SHIFT_ZERO_BYPASS_EN, after 5 edges without.

Source files
------------

// File: rtl/alu_shift_seq.sv
// Sequential shifter/rotator: one power-of-two stage per clock, AMT_W stages per request.
// Optional macro ALU_SHIFT_ZERO_BYPASS_EN: amount=0 or pass-through requests finish on the accept edge.
module alu_shift_seq #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_RUN  | applying one shift stage per edge
  // S_DONE | result valid, done pulse; may accept the next request
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [2:0] M_SHL  = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHRA = 3'b010;
  localparam logic [2:0] M_ROL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [AMT_W-1:0] ONE = {{(AMT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic             accept, bypass, last;
  logic [AMT_W-1:0] step;
  logic [2*WIDTH-1:0] rol_w, ror_w;
  logic [WIDTH-1:0] stage_out;

  assign accept = start && (state_q != S_RUN);
  assign last   = (int'(cnt_q) == AMT_W - 1);

`ifdef ALU_SHIFT_ZERO_BYPASS_EN
  assign bypass = (amount == '0) || (mode > M_ROR);
`else
  assign bypass = 1'b0;
`endif

  // amt_q is shifted right each stage, so bit 0 always gates the current stage
  always_comb begin
    step      = ONE << cnt_q;
    rol_w     = {work_q, work_q} << step;
    ror_w     = {work_q, work_q} >> step;
    stage_out = work_q;
    if (amt_q[0]) begin
      case (mode_q)
        M_SHL:   stage_out = work_q << step;
        M_SHR:   stage_out = work_q >> step;
        M_SHRA:  stage_out = $signed(work_q) >>> step;
        M_ROL:   stage_out = rol_w[2*WIDTH-1:WIDTH];
        M_ROR:   stage_out = ror_w[WIDTH-1:0];
        default: stage_out = work_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!clear_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = bypass ? S_DONE : S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  state_d = start ? (bypass ? S_DONE : S_RUN) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q != S_RUN);
    busy  = (state_q == S_RUN);
    done  = (state_q == S_DONE);
  end

  always_comb begin
    work_d   = work_q;
    amt_d    = amt_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    if (accept) begin
      work_d = data_in;
      amt_d  = amount;
      mode_d = mode;
      cnt_d  = '0;
      if (bypass) begin
        result_d = data_in;
        zero_d   = (data_in == '0);
      end
    end else if (state_q == S_RUN) begin
      work_d = stage_out;
      amt_d  = amt_q >> 1;
      cnt_d  = last ? '0 : cnt_q + 1'b1;
      if (last) begin
        result_d = stage_out;
        zero_d   = (stage_out == '0);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      work_q   <= '0;
      amt_q    <= '0;
      mode_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      work_q   <= work_d;
      amt_q    <= amt_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;

endmodule
